// File: rtl/rr_mux4_arbiter.sv
// Four-channel valid/ready merge with round-robin arbitration into a single
// output register; each held word carries the index of the channel it came from.
module rr_mux4_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
  input  logic                  out_ready
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [1:0]        out_sel_reg;
  logic [1:0]        ptr_reg;

  logic              load;
  logic [DATA_W-1:0] word [4];
  logic [1:0]        cand_idx [4];
  logic [3:0]        cand_valid;
  logic              grant_any;
  logic [1:0]        grant_idx;

  // The register can take a new word when it is empty or drains this cycle.
  assign load = !out_valid_reg | out_ready;

  // Candidate gi is the channel visited gi-th in search order starting at ptr.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      assign word[gi]       = in_data[gi*DATA_W +: DATA_W];
      assign cand_idx[gi]   = ptr_reg + 2'(gi);
      assign cand_valid[gi] = in_valid[cand_idx[gi]];
    end
  endgenerate

  // Descending scan so the earliest candidate in search order has the final say.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (cand_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load && grant_any) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= 2'd0;
      ptr_reg       <= 2'd0;
    end else if (load) begin
      if (grant_any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= word[grant_idx];
        out_sel_reg   <= grant_idx;
        ptr_reg       <= grant_idx + 2'd1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: a per-cycle reference model of the
// merge plus hand-computed expectations for the main scenarios.
module tb_rr_mux4_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  rr_mux4_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: holding register contents and the next channel to favour.
  bit       m_init = 0;
  bit       m_valid;
  int       m_data;
  int       m_sel;
  int       m_ptr;

  function automatic int winner();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    for (int i = 0; i < 4; i++) begin
      if (in_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = winner();
    if (rst) begin
      m_init = 1; m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (m_init) begin
      if (w >= 0) begin
        m_valid = 1;
        m_data  = (in_data >> (8 * w)) & 32'hFF;
        m_sel   = w;
        m_ptr   = (w + 1) % 4;
      end else if (!m_valid || out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    if (m_init) begin
      w = winner();
      check("in_ready", in_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
      check("out_valid", out_valid, m_valid);
      check("out_data", out_data, m_data);
      check("out_sel", out_sel, m_sel);
      if (out_valid && out_ready && !rst)
        $display("xfer sel=%0d data=%02h t=%0t", out_sel, out_data, $time);
    end
  end

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d, input logic ordy);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DATA_A = 32'h33_A5_22_11;
  localparam logic [31:0] DATA_C = 32'hC3_C2_C1_C0;

  initial begin
    drive(1'b1, 4'h0, 32'h0, 1'b1);
    next_cycle();

    // Reset held two cycles with every channel requesting.
    drive(1'b1, 4'hF, DATA_C, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 4'b0000);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sel", out_sel, 2'd0);
      check("rst_out_data", out_data, 8'h00);
      next_cycle();
    end

    // Single request from ch2, then wrap from ptr=3 to ch3 and ch0.
    drive(1'b0, 4'b0100, DATA_A, 1'b1);
    @(negedge clk); check("t2_in_ready", in_ready, 4'b0100);
    next_cycle();
    drive(1'b0, 4'b1001, DATA_A, 1'b1);
    @(negedge clk);
    check("t2_out_valid", out_valid, 1'b1);
    check("t2_out_data", out_data, 8'hA5);
    check("t2_out_sel", out_sel, 2'd2);
    check("t5_in_ready_ch3", in_ready, 4'b1000);
    next_cycle();
    drive(1'b0, 4'b0001, DATA_A, 1'b1);
    @(negedge clk);
    check("t5_out_sel_ch3", out_sel, 2'd3);
    check("t5_out_data_ch3", out_data, 8'h33);
    check("t5_in_ready_ch0", in_ready, 4'b0001);
    next_cycle();
    drive(1'b0, 4'b0000, DATA_A, 1'b1);
    @(negedge clk);
    check("t5_out_sel_ch0", out_sel, 2'd0);
    check("t5_out_data_ch0", out_data, 8'h11);
    next_cycle();
    @(negedge clk);
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_out_data_kept", out_data, 8'h11);

    // Fresh reset, then all channels steady: 0,1,2,3,0 at one word per cycle.
    next_cycle();
    drive(1'b1, 4'h0, DATA_C, 1'b1);
    next_cycle();
    drive(1'b0, 4'hF, DATA_C, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5) check("t3_in_ready", in_ready, 32'd1 << (i % 4));
      if (i > 0) begin
        check("t3_out_valid", out_valid, 1'b1);
        check("t3_out_sel", out_sel, (i - 1) % 4);
        check("t3_out_data", out_data, 8'hC0 + ((i - 1) % 4));
      end
      if (i == 4) begin
        next_cycle();
        drive(1'b0, 4'hF, DATA_C, 1'b0);
      end else if (i < 5) begin
        next_cycle();
      end
    end

    // Backpressure for 3 cycles: no grants, held word stable.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready", in_ready, 4'b0000);
      check("t4_out_sel", out_sel, 2'd0);
      check("t4_out_data", out_data, 8'hC0);
      next_cycle();
    end
    drive(1'b0, 4'hF, DATA_C, 1'b1);
    @(negedge clk); check("t4_release_in_ready", in_ready, 4'b0010);
    next_cycle();
    drive(1'b0, 4'h0, DATA_C, 1'b0);
    @(negedge clk);
    check("t4_new_sel", out_sel, 2'd1);
    check("t4_new_data", out_data, 8'hC1);

    // Reset while holding the ch1 word, then ch0 wins first.
    next_cycle();
    drive(1'b1, 4'h0, DATA_C, 1'b0);
    @(negedge clk); check("t6_rst_in_ready", in_ready, 4'b0000);
    next_cycle();
    drive(1'b0, 4'hF, DATA_C, 1'b1);
    @(negedge clk);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_in_ready", in_ready, 4'b0001);
    next_cycle();
    drive(1'b0, 4'h0, DATA_C, 1'b1);
    @(negedge clk);
    check("t6_out_sel", out_sel, 2'd0);
    check("t6_out_data", out_data, 8'hC0);
    next_cycle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
